// File: rtl/muldiv_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : muldiv_pkg                                                   |
// | Description : Shared types and constants for the iterative multiply/divide |
// |               unit: operation encodings, FSM state encoding, datapath      |
// |               class selector and the divide-by-zero quotient fill bit.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

  // Operation encodings as presented on the op bus.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Selects which single-step datapath the iteration block applies.
  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } opclass_e;

  // Divide by zero returns a quotient filled with this bit (all ones).
  localparam logic DIVZ_QUOTIENT_BIT = 1'b1;

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/muldiv_if.sv
// +----------------------------------------------------------------------------+
// | Module      : muldiv_if                                                    |
// | Description : Request/result bundle between the core controller (master)  |
// |               and the multiply/divide unit (slave).                        |
// |   start      master->slave  request an operation                           |
// |   op         master->slave  operation select (op_e)                        |
// |   a, b       master->slave  rs/rt operands (dividend/divisor for divides)  |
// |   mthi/mtlo  master->slave  write a into HI / LO                           |
// |   hi, lo     slave->master  architectural HI/LO registers                  |
// |   busy       slave->master  operation in flight                            |
// |   done       slave->master  one-cycle pulse on result commit               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );

endinterface : muldiv_if

`default_nettype wire

// File: rtl/muldiv_step.sv
// +----------------------------------------------------------------------------+
// | Module      : muldiv_step                                                  |
// | Description : One combinational iteration of the multiply/divide datapath.|
// |               Accumulator layout is {extra_bit, upper[WIDTH], lower[WIDTH]}|
// |   acc_i   in   2*WIDTH+1  current accumulator                              |
// |   opnd_i  in   WIDTH      multiplicand / divisor magnitude                 |
// |   cls_i   in   1          CLS_MUL: shift-add, CLS_DIV: restoring divide    |
// |   acc_o   out  2*WIDTH+1  accumulator after one step                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  opclass_e         cls_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_shl;
  logic [WIDTH+1:0] w_diff;

  // Multiply: the multiplier sits in the lower half and is consumed LSB
  // first; the partial product grows into the upper half. The extra top
  // bit holds the carry of the add before it is shifted back down.
  assign w_addend = acc_i[0] ? {1'b0, opnd_i} : '0;
  assign w_sum    = acc_i[2*WIDTH:WIDTH] + w_addend;

  // Restoring divide: shift the dividend into the remainder half, then try
  // to subtract the divisor. The remainder can briefly need WIDTH+1 bits
  // after the shift, so the trial subtract is done on WIDTH+2 bits.
  assign w_shl  = {acc_i[2*WIDTH-1:0], 1'b0};
  assign w_diff = {1'b0, w_shl[2*WIDTH:WIDTH]} - {2'b00, opnd_i};

  always_comb begin
    acc_o = acc_i;
    if (cls_i == CLS_MUL) begin
      acc_o = {1'b0, w_sum, acc_i[WIDTH-1:1]};
    end else if (w_diff[WIDTH+1]) begin
      // Borrow: divisor did not fit, keep the shifted value, quotient bit 0.
      acc_o = w_shl;
    end else begin
      acc_o = {w_diff[WIDTH:0], w_shl[WIDTH-1:1], 1'b1};
    end
  end

endmodule : muldiv_step

`default_nettype wire

// File: rtl/muldiv.sv
// +----------------------------------------------------------------------------+
// | Module      : muldiv                                                       |
// | Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO |
// |               registers and MTHI/MTLO support. An operation takes         |
// |               WIDTH+1 cycles: WIDTH iteration steps plus a sign-fix/commit.|
// |   clk     in   1      rising-edge clock                                   |
// |   reset   in   1      asynchronous, active-low reset                      |
// |   bus     slave       muldiv_if (start/op/a/b/mthi/mtlo, hi/lo/busy/done) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int            CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST_STEP = CW'(WIDTH - 1);
  localparam int            AW          = 2 * WIDTH + 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             divz_q, divz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_in_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_is_div;
  opclass_e         w_cls;
  logic [AW-1:0]    w_step_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Operand magnitudes. For the most negative value the negation wraps to
  // itself, which read as unsigned is exactly the correct magnitude.
  assign w_in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_mag_a     = (w_in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b     = (w_in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign w_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign w_cls    = w_is_div ? CLS_DIV : CLS_MUL;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .opnd_i (mag_b_q),
    .cls_i  (w_cls),
    .acc_o  (w_step_acc)
  );

  // Sign correction applied at commit. Unsigned ops latch both signs as 0,
  // so the same expressions serve all four operations.
  assign w_prod = (sign_a_q ^ sign_b_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign w_rem  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  // With a zero divisor the restoring loop already leaves the magnitude of a
  // in the remainder, so only the quotient needs forcing.
  assign w_quot = divz_q ? {WIDTH{DIVZ_QUOTIENT_BIT}}
                : ((sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    divz_d   = divz_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Start wins over any simultaneous register move.
          op_d     = bus.op;
          acc_d    = {{(WIDTH+1){1'b0}}, w_mag_a};
          mag_b_d  = w_mag_b;
          sign_a_d = w_in_signed & bus.a[WIDTH-1];
          sign_b_d = w_in_signed & bus.b[WIDTH-1];
          divz_d   = (bus.b == '0);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          if (bus.mthi) hi_d = bus.a;
          if (bus.mtlo) lo_d = bus.a;
        end
      end
      ST_RUN: begin
        acc_d = w_step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_STEP) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (w_is_div) begin
          hi_d = w_rem;
          lo_d = w_quot;
        end else begin
          {hi_d, lo_d} = w_prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_MULT;
      acc_q    <= '0;
      mag_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      divz_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      mag_b_q  <= mag_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      divz_q   <= divz_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : muldiv

`default_nettype wire

// File: tb/tb_muldiv.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_muldiv                                                    |
// | Description : Scoreboard bench for muldiv. Issued operations push their   |
// |               expected {HI,LO} (from a plain-arithmetic model) into a      |
// |               queue; a monitor pops and compares on every done pulse.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] model(input op_e o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      OP_MULT:  p = 64'(sx * sy);
      OP_MULTU: p = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else        p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result_hi", bus.hi, mon_exp[63:32]);
        chk("result_lo", bus.lo, mon_exp[31:0]);
      end
    end
  end

  // Issue one operation and follow it to completion, checking latency and
  // busy. 'disturb' pokes start/mthi with new operands mid-run; 'with_mtlo'
  // raises mtlo alongside start.
  task automatic do_op(input op_e o, input logic [31:0] x, input logic [31:0] y,
                       input bit disturb, input bit with_mtlo);
    int          lat;
    bit          busy_all;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic [63:0] e;
    prev_hi = m_hi;
    prev_lo = m_lo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.mtlo  = with_mtlo;
    e = model(o, x, y);
    exp_q.push_back(e);
    m_hi = e[63:32];
    m_lo = e[31:0];
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    if (with_mtlo) chk("mtlo_dropped_on_start", bus.lo, prev_lo);
    lat      = 0;
    busy_all = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_all = 1'b0;
      if (disturb && lat == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'hA5A5_A5A5;
        bus.b     = 32'd3;
        bus.mthi  = 1'b1;
      end
      if (disturb && lat == 8) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        chk("mthi_ignored_in_run", bus.hi, prev_hi);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    chk("latency", 32'(lat), 32'd33);
    chk("busy_during_op", {31'b0, busy_all}, 32'd1);
    chk("busy_low_with_done", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_e         ro;
    logic [31:0] rx, ry;
    int          k;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    m_hi      = '0;
    m_lo      = '0;
    #23;
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed operations.
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, 1'b0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    do_op(OP_DIVU,  32'd7,         32'd2,         1'b0, 1'b0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(OP_DIVU,  32'h0000_1234, 32'd0,         1'b0, 1'b0);
    do_op(OP_DIV,   32'hFFFF_FF00, 32'd0,         1'b0, 1'b0);

    // Start and mthi during RUN are ignored; the first result stands.
    do_op(OP_MULTU, 32'h0012_3456, 32'd789, 1'b1, 1'b0);

    // mthi in IDLE.
    @(negedge clk);
    bus.a    = 32'hA5A5_A5A5;
    bus.mthi = 1'b1;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    m_hi = 32'hA5A5_A5A5;
    chk("mthi_idle_hi", bus.hi, m_hi);
    chk("mthi_idle_lo_kept", bus.lo, m_lo);

    // Both moves together.
    @(negedge clk);
    bus.a    = 32'h5A5A_0F0F;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    m_hi = 32'h5A5A_0F0F;
    m_lo = 32'h5A5A_0F0F;
    chk("mthi_mtlo_hi", bus.hi, m_hi);
    chk("mthi_mtlo_lo", bus.lo, m_lo);

    // HI/LO hold while idle.
    repeat (4) @(posedge clk);
    #1;
    chk("hold_hi", bus.hi, m_hi);
    chk("hold_lo", bus.lo, m_lo);

    // start together with mtlo: only the operation happens.
    do_op(OP_MULTU, 32'h11, 32'h22, 1'b0, 1'b1);

    // Randomized operations with boundary-heavy operand choices.
    for (int i = 0; i < 24; i++) begin
      ro = op_e'(2'($urandom_range(0, 3)));
      k  = $urandom_range(0, 7);
      rx = (k == 7) ? 32'h8000_0000 : 32'($urandom);
      k  = $urandom_range(0, 7);
      case (k)
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = 32'($urandom);
      endcase
      do_op(ro, rx, ry, 1'b0, 1'b0);
    end

    // Reset during RUN discards the operation and clears everything.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrun_reset_done", {31'b0, bus.done}, 32'd0);
    chk("midrun_reset_hi", bus.hi, 32'd0);
    chk("midrun_reset_lo", bus.lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_reset_hi", bus.hi, 32'd0);
    chk("idle_after_reset_busy", {31'b0, bus.busy}, 32'd0);
    do_op(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_muldiv

`default_nettype wire
